aes_iter_enc: RTL



---
 rtl/aes_iter_enc.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/aes_iter_enc.sv
// Iterative AES encryption core: one round per clock, with round keys
// expanded on the fly from a sliding key window. The key length is chosen at
// elaboration (128 or 256). Valid/ready handshakes on both sides let the
// downstream consumer hold a finished block.
//
// Handshake rule (both sides): a transfer happens at a rising edge where valid
// and ready are both high. in_ready is high only in IDLE, and out_valid holds
// with a stable cipher until out_ready completes the transfer.
module aes_iter_enc #(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       plaintext,
    input  logic [KEY_LEN-1:0] cipher_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       cipher,
    output logic               busy,
    output logic [1:0]         dbg_state
);
    localparam int NR = (KEY_LEN == 256) ? 14 : 10;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} fsm_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    fsm_t               r_fsm;
    logic [127:0]       r_state;
    logic [KEY_LEN-1:0] r_key;
    logic [3:0]         r_round;
    logic [7:0]         r_rcon;
    logic [127:0]       r_cipher;
    logic               r_out_valid;

    logic [127:0]       w_sb, w_sr, w_mc, w_rk, w_round_out;
    logic [KEY_LEN-1:0] w_key_next;
    logic               w_rcon_adv;
    logic               w_last;
    logic               w_accept;

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_valid = r_out_valid;
    assign cipher    = r_cipher;
    assign dbg_state = r_fsm;
    assign w_accept  = (r_fsm == S_IDLE) && in_valid;
    // Last round is decided by the counter alone; rcon is only a key-schedule input.
    assign w_last    = (r_round == 4'(NR));

    // SubBytes, ShiftRows (row r rotates left by r columns) and MixColumns.
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[127 - 8*i -: 8] = sbox(r_state[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127 - 8*(r + 4*c) -: 8] = w_sb[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127 - 32*c -: 32] = mix_col(w_sr[127 - 32*c -: 32]);
        end
    end

    assign w_round_out = (w_last ? w_sr : w_mc) ^ w_rk;

    if (KEY_LEN == 128) begin : g_k128
        logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
        // Next four schedule words; they are this round's key and the new window.
        always_comb begin
            w_t  = sub_word(rot_word(r_key[31:0])) ^ {r_rcon, 24'h0};
            w_n0 = r_key[127:96] ^ w_t;
            w_n1 = r_key[95:64]  ^ w_n0;
            w_n2 = r_key[63:32]  ^ w_n1;
            w_n3 = r_key[31:0]   ^ w_n2;
        end
        assign w_rk       = {w_n0, w_n1, w_n2, w_n3};
        assign w_key_next = w_rk;
        assign w_rcon_adv = 1'b1;
    end else if (KEY_LEN == 256) begin : g_k256
        logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
        logic        w_first;
        // Even rounds apply RotWord+SubWord+rcon to the last word, odd rounds SubWord only.
        always_comb begin
            w_t  = !r_round[0] ? (sub_word(rot_word(r_key[31:0])) ^ {r_rcon, 24'h0})
                               : sub_word(r_key[31:0]);
            w_n0 = r_key[255:224] ^ w_t;
            w_n1 = r_key[223:192] ^ w_n0;
            w_n2 = r_key[191:160] ^ w_n1;
            w_n3 = r_key[159:128] ^ w_n2;
        end
        // Round 1 takes words 4..7 of the loaded key and leaves the window alone.
        assign w_first    = (r_round == 4'd1);
        assign w_rk       = w_first ? r_key[127:0] : {w_n0, w_n1, w_n2, w_n3};
        assign w_key_next = w_first ? r_key : {r_key[127:0], w_n0, w_n1, w_n2, w_n3};
        assign w_rcon_adv = !w_first && !r_round[0];
    end else begin : g_bad_key_len
        $error("aes_iter_enc: KEY_LEN must be 128 or 256");
    end

    // Control FSM with round counter, rcon and the registered output block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_cipher    <= '0;
            r_round     <= 4'd0;
            r_rcon      <= 8'h01;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_round <= 4'd1;
                        r_rcon  <= 8'h01;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_round <= r_round + 4'd1;
                    if (w_rcon_adv) begin
                        r_rcon <= xtime(r_rcon);
                    end
                    if (w_last) begin
                        r_cipher    <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A new in_valid here is not taken; it waits for IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    // Cipher state and key window: loaded at accept, advanced once per round.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_state <= plaintext ^ cipher_key[KEY_LEN-1 -: 128];
            r_key   <= cipher_key;
        end else if (r_fsm == S_RUN) begin
            r_state <= w_round_out;
            r_key   <= w_key_next;
        end
    end
endmodule
